// File: rtl/sc_datapath_pkg.sv
// sc_datapath_pkg
// Shared encodings for the SC datapath responder:
//   - ALU operation codes
//   - BUSA/BUSB mux select codes
//   - write-decoder "no write" code
//   - shifter control codes
//   - default bus width
package sc_datapath_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    ALU_PASS = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_NOT  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_ADD  = 4'b1000,
    ALU_SUB  = 4'b1001,
    ALU_INC  = 4'b1010,
    ALU_DEC  = 4'b1011
  } alu_op_e;

  typedef enum logic [2:0] {
    MUX_GEN0 = 3'b000,
    MUX_GEN1 = 3'b001,
    MUX_GEN2 = 3'b010,
    MUX_GEN3 = 3'b011,
    MUX_FIX0 = 3'b100,
    MUX_FIX1 = 3'b101,
    MUX_NONE = 3'b110
  } mux_sel_e;

  // Any code with the MSB set suppresses the register write.
  localparam logic [2:0] DEC_NONE = 3'b100;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'b00,
    SH_LEFT  = 2'b01,
    SH_RIGHT = 2'b10,
    SH_HOLD2 = 2'b11
  } shift_sel_e;

endpackage

// File: rtl/sc_datapath_alu.sv
// sc_datapath_alu
// Combinational ALU for the SC datapath.
// Ports:
//   a, b      in  W      operands (BUSA, BUSB)
//   op        in  SEL_W  operation code (alu_op_e)
//   result    out W      operation result
//   carry     out 1      carry out of the W+1-bit sum (arith ops only)
//   overflow  out 1      signed overflow (arith ops only)
module sc_datapath_alu
  import sc_datapath_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int SEL_W = 4
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [SEL_W-1:0] op,
  output logic [W-1:0]     result,
  output logic             carry,
  output logic             overflow
);

  // All arithmetic ops share one adder: a + operand + carry_in.
  logic [W-1:0] operand;
  logic         carry_in;
  logic [W:0]   sum;

  always_comb begin
    operand  = '0;
    carry_in = 1'b0;
    case (op)
      ALU_ADD: operand = b;
      ALU_SUB: begin operand = ~b; carry_in = 1'b1; end
      ALU_INC: carry_in = 1'b1;
      ALU_DEC: operand = '1;
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, operand} + {{W{1'b0}}, carry_in};
  end

  always_comb begin
    result   = a;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      ALU_NOT: result = ~a;
      ALU_XOR: result = a ^ b;
      ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC: begin
        result   = sum[W-1:0];
        carry    = sum[W];
        // Same-sign addends producing a different-sign result.
        overflow = (a[W-1] == operand[W-1]) && (sum[W-1] != a[W-1]);
      end
      default: result = a;
    endcase
  end

endmodule

// File: rtl/sc_datapath_exec.sv
// sc_datapath_exec
// Datapath responder executing one SC_STATEMACHINE control word per clock:
// 4 general registers, 2 constant registers, BUSA/BUSB read muxes, ALU,
// shift register driving BUSC and a registered flag set returned active low.
// Build option: define SC_DATAPATH_ARITH_SHIFT_EN for arithmetic right shift
// (MSB replicated); otherwise right shift fills the MSB with 0.
// Ports:
//   SC_DATAPATH_CLOCK_50                        in  clock, rising edge
//   SC_DATAPATH_Reset_InLow                     in  async active-low reset
//   SC_DATAPATH_DecoderSelectionWrite_In        in  0nn write GenREG_nn from BUSC
//   SC_DATAPATH_MUXSelectionBUSA_In/BUSB_In     in  bus source selects
//   SC_DATAPATH_ALUSelection_In                 in  ALU op
//   SC_DATAPATH_RegSHIFTERLoad_InLow            in  0 = load ALU result
//   SC_DATAPATH_RegSHIFTERShiftSelection_InLow  in  01 left, 10 right
//   SC_DATAPATH_BUSC_Out                        out shifter contents
//   SC_DATAPATH_{Overflow,Carry,Negative,Zero}_OutLow out flags, active low
module sc_datapath_exec
  import sc_datapath_pkg::*;
#(
  parameter int DATAWIDTH_BUS                  = DATA_W,
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter logic [DATAWIDTH_BUS-1:0] REGFIX0_VALUE = 'h01,
  parameter logic [DATAWIDTH_BUS-1:0] REGFIX1_VALUE = 'h05
) (
  input  logic                                      SC_DATAPATH_CLOCK_50,
  input  logic                                      SC_DATAPATH_Reset_InLow,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_DecoderSelectionWrite_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_MUXSelectionBUSA_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_MUXSelectionBUSB_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DATAPATH_ALUSelection_In,
  input  logic                                      SC_DATAPATH_RegSHIFTERLoad_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DATAPATH_RegSHIFTERShiftSelection_InLow,
  output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_BUSC_Out,
  output logic                                      SC_DATAPATH_Overflow_OutLow,
  output logic                                      SC_DATAPATH_Carry_OutLow,
  output logic                                      SC_DATAPATH_Negative_OutLow,
  output logic                                      SC_DATAPATH_Zero_OutLow
);

  localparam int W = DATAWIDTH_BUS;

  logic [W-1:0] gen_reg [4];
  logic [W-1:0] shifter_reg;
  logic [3:0]   flags_reg;      // {V, C, N, Z}, active high internally
  logic [W-1:0] bus_a, bus_b;
  logic [W-1:0] alu_result;
  logic         alu_carry, alu_overflow;
  logic         shift_in;

  function automatic logic [W-1:0] bus_select(input logic [DATAWIDTH_MUX_SELECTION-1:0] sel,
                                               input logic [W-1:0] r0, input logic [W-1:0] r1,
                                               input logic [W-1:0] r2, input logic [W-1:0] r3);
    case (sel)
      MUX_GEN0: return r0;
      MUX_GEN1: return r1;
      MUX_GEN2: return r2;
      MUX_GEN3: return r3;
      MUX_FIX0: return REGFIX0_VALUE;
      MUX_FIX1: return REGFIX1_VALUE;
      default:  return '0;
    endcase
  endfunction

  assign bus_a = bus_select(SC_DATAPATH_MUXSelectionBUSA_In, gen_reg[0], gen_reg[1], gen_reg[2], gen_reg[3]);
  assign bus_b = bus_select(SC_DATAPATH_MUXSelectionBUSB_In, gen_reg[0], gen_reg[1], gen_reg[2], gen_reg[3]);

  sc_datapath_alu #(
    .W     (W),
    .SEL_W (DATAWIDTH_ALU_SELECTION)
  ) u_alu (
    .a        (bus_a),
    .b        (bus_b),
    .op       (SC_DATAPATH_ALUSelection_In),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow)
  );

`ifdef SC_DATAPATH_ARITH_SHIFT_EN
  assign shift_in = shifter_reg[W-1];
`else
  assign shift_in = 1'b0;
`endif

  // Load has priority over shifting; flags only change on a load.
  always_ff @(posedge SC_DATAPATH_CLOCK_50 or negedge SC_DATAPATH_Reset_InLow) begin
    if (!SC_DATAPATH_Reset_InLow) begin
      shifter_reg <= '0;
      flags_reg   <= '0;
    end else if (!SC_DATAPATH_RegSHIFTERLoad_InLow) begin
      shifter_reg <= alu_result;
      flags_reg   <= {alu_overflow, alu_carry, alu_result[W-1], (alu_result == '0)};
    end else begin
      case (SC_DATAPATH_RegSHIFTERShiftSelection_InLow)
        SH_LEFT:  shifter_reg <= {shifter_reg[W-2:0], 1'b0};
        SH_RIGHT: shifter_reg <= {shift_in, shifter_reg[W-1:1]};
        default:  ;
      endcase
    end
  end

  // General registers capture the pre-edge BUSC, so a same-cycle load
  // stores the old shifter value.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_gen_reg
      logic [W-1:0] value_reg;
      always_ff @(posedge SC_DATAPATH_CLOCK_50 or negedge SC_DATAPATH_Reset_InLow) begin
        if (!SC_DATAPATH_Reset_InLow)
          value_reg <= '0;
        else if (SC_DATAPATH_DecoderSelectionWrite_In == DATAWIDTH_DECODER_SELECTION'(gi))
          value_reg <= shifter_reg;
      end
      assign gen_reg[gi] = value_reg;
    end
  endgenerate

  assign SC_DATAPATH_BUSC_Out        = shifter_reg;
  assign SC_DATAPATH_Overflow_OutLow = ~flags_reg[3];
  assign SC_DATAPATH_Carry_OutLow    = ~flags_reg[2];
  assign SC_DATAPATH_Negative_OutLow = ~flags_reg[1];
  assign SC_DATAPATH_Zero_OutLow     = ~flags_reg[0];

endmodule

// File: tb/tb_sc_datapath_exec.sv
module tb_sc_datapath_exec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dec, mux_a, mux_b;
  logic [3:0] alu_op;
  logic       load_n;
  logic [1:0] shift;
  logic [7:0] busc;
  logic       v_n, c_n, n_n, z_n;

  always #5 clk = ~clk;

  sc_datapath_exec dut (
    .SC_DATAPATH_CLOCK_50                       (clk),
    .SC_DATAPATH_Reset_InLow                    (rst_n),
    .SC_DATAPATH_DecoderSelectionWrite_In       (dec),
    .SC_DATAPATH_MUXSelectionBUSA_In            (mux_a),
    .SC_DATAPATH_MUXSelectionBUSB_In            (mux_b),
    .SC_DATAPATH_ALUSelection_In                (alu_op),
    .SC_DATAPATH_RegSHIFTERLoad_InLow           (load_n),
    .SC_DATAPATH_RegSHIFTERShiftSelection_InLow (shift),
    .SC_DATAPATH_BUSC_Out                       (busc),
    .SC_DATAPATH_Overflow_OutLow                (v_n),
    .SC_DATAPATH_Carry_OutLow                   (c_n),
    .SC_DATAPATH_Negative_OutLow                (n_n),
    .SC_DATAPATH_Zero_OutLow                    (z_n)
  );

  typedef struct {
    logic [7:0] busc;
    logic [3:0] flags_n;   // {V, C, N, Z} active low
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Reference model state, plain integers.
  int m_regs[4];
  int m_shf;
  int m_v, m_c, m_n, m_z;

`ifdef SC_DATAPATH_ARITH_SHIFT_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function int bus_val(input int sel);
    if (sel < 4) return m_regs[sel];
    if (sel == 4) return 1;
    if (sel == 5) return 5;
    return 0;
  endfunction

  function void model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_shf = 0; m_v = 0; m_c = 0; m_n = 0; m_z = 0;
  endfunction

  function void model_step(input int d, input int a, input int b, input int op,
                           input int ld, input int sh);
    int va, vb, res, full, sr, cv, vv, old;
    va = bus_val(a); vb = bus_val(b); old = m_shf;
    cv = 0; vv = 0; full = 0; sr = 0; res = va;
    case (op)
      1: res = va | vb;
      2: res = va & vb;
      3: res = 255 - va;
      4: res = va ^ vb;
      8:  begin full = va + vb;            sr = sgn(va) + sgn(vb); end
      9:  begin full = va + (255 - vb) + 1; sr = sgn(va) - sgn(vb); end
      10: begin full = va + 1;             sr = sgn(va) + 1;       end
      11: begin full = va + 255;           sr = sgn(va) - 1;       end
      default: res = va;
    endcase
    if (op >= 8 && op <= 11) begin
      res = full % 256;
      cv  = (full > 255) ? 1 : 0;
      vv  = (sr > 127 || sr < -128) ? 1 : 0;
    end
    if (ld == 0) begin
      m_shf = res;
      m_v = vv; m_c = cv; m_n = (res >= 128) ? 1 : 0; m_z = (res == 0) ? 1 : 0;
    end else if (sh == 1) begin
      m_shf = (old * 2) % 256;
    end else if (sh == 2) begin
      m_shf = old / 2 + ((ARITH && old >= 128) ? 128 : 0);
    end
    if (d < 4) m_regs[d] = old;
  endfunction

  function automatic logic [3:0] model_flags_n();
    logic [3:0] f;
    f[3] = (m_v == 0); f[2] = (m_c == 0); f[1] = (m_n == 0); f[0] = (m_z == 0);
    return f;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_idle();
    dec = 3'b100; mux_a = 3'b000; mux_b = 3'b000; alu_op = 4'b0000; load_n = 1'b1; shift = 2'b00;
  endtask

  // Drive one control word for the coming rising edge and queue its expected result.
  task automatic issue(input int d, input int a, input int b, input int op,
                       input int ld, input int sh);
    exp_t e;
    @(negedge clk);
    dec = 3'(d); mux_a = 3'(a); mux_b = 3'(b); alu_op = 4'(op);
    load_n = 1'(ld); shift = 2'(sh);
    model_step(d, a, b, op, ld, sh);
    e.busc = 8'(m_shf);
    e.flags_n = model_flags_n();
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every rising edge with an outstanding word, compare the outcome.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d: busc=%02h flags_n=%04b (exp %02h %04b)",
               txn, busc, {v_n, c_n, n_n, z_n}, e.busc, e.flags_n);
      check("sb_busc", busc, e.busc);
      check("sb_flags", {4'b0, v_n, c_n, n_n, z_n}, {4'b0, e.flags_n});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int ops[9] = '{0, 1, 2, 3, 4, 8, 9, 10, 11};

  initial begin
    model_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_busc", busc, 8'h00);
    check("reset_flags", {4'b0, v_n, c_n, n_n, z_n}, 8'h0F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // MOV FIX1 -> GEN2
    issue(4, 5, 0, 0, 1, 0);
    issue(4, 5, 0, 0, 0, 0);
    after_edge();
    check("mov_busc", busc, 8'h05);
    check("mov_flags", {4'b0, v_n, c_n, n_n, z_n}, 8'h0F);
    issue(2, 0, 0, 0, 1, 0);

    // ADD GEN2 + FIX1 -> GEN3
    issue(4, 2, 5, 8, 0, 0);
    after_edge();
    check("add_busc", busc, 8'h0A);
    check("add_flags", {4'b0, v_n, c_n, n_n, z_n}, 8'h0F);
    issue(3, 0, 0, 0, 1, 0);

    // Build 0x80 by shifting FIX0 left, store in GEN0; DEC it to 0x7F in GEN1.
    issue(4, 4, 0, 0, 0, 0);
    repeat (7) issue(4, 0, 0, 0, 1, 1);
    after_edge();
    check("shl_to_80", busc, 8'h80);
    issue(0, 0, 0, 0, 1, 0);
    issue(4, 0, 0, 11, 0, 0);
    after_edge();
    check("dec_busc", busc, 8'h7F);
    issue(1, 0, 0, 0, 1, 0);

    // 0x7F + 0x01: signed overflow, negative, no carry.
    issue(4, 1, 4, 8, 0, 0);
    after_edge();
    check("ovf_busc", busc, 8'h80);
    check("ovf_flags", {4'b0, v_n, c_n, n_n, z_n}, 8'h05);

    // FIX1 - FIX1: zero, carry (no borrow).
    issue(4, 5, 5, 9, 0, 0);
    after_edge();
    check("sub_busc", busc, 8'h00);
    check("sub_flags", {4'b0, v_n, c_n, n_n, z_n}, 8'h0A);

    // Shifter boundaries.
    issue(4, 0, 4, 1, 0, 0);
    after_edge();
    check("or_81", busc, 8'h81);
    issue(4, 0, 0, 0, 1, 1);
    after_edge();
    check("shl_81", busc, 8'h02);
    issue(4, 0, 0, 0, 0, 0);
    issue(4, 0, 0, 0, 1, 2);
    after_edge();
    check("shr_80", busc, ARITH ? 8'hC0 : 8'h40);
    issue(4, 5, 0, 0, 0, 1);
    after_edge();
    check("load_beats_shift", busc, 8'h05);
    issue(4, 3, 0, 0, 0, 0);
    after_edge();
    check("read_gen3", busc, 8'h0A);

    // Mid-sequence reset clears at once.
    @(negedge clk);
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busc", busc, 8'h00);
    check("midrst_flags", {4'b0, v_n, c_n, n_n, z_n}, 8'h0F);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(4, 2, 0, 0, 0, 0);
    after_edge();
    check("midrst_gen2", busc, 8'h00);
    check("midrst_zero", {4'b0, v_n, c_n, n_n, z_n}, 8'h0E);

    // Randomized control words.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : ops[$urandom_range(0, 8)];
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), op,
            $urandom_range(0, 1), $urandom_range(0, 3));
    end
    @(negedge clk);
    drive_idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
